// File: rtl/axil_sram.sv
// AXI-Lite word-addressed SRAM slave, one transaction at a time, with configurable response latency.
// Define AXIL_SRAM_RAND_DELAY_EN to add LFSR-driven extra latency and ready throttling.
module axil_sram #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                RD_LAT      = 1,
  parameter int                WR_LAT      = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_ar_valid_i,
  input  logic [ADDR_W-1:0]   slv_ar_addr_i,
  output logic                slv_ar_ready_o,
  output logic                slv_r_valid_o,
  output logic [DATA_W-1:0]   slv_r_data_o,
  output logic [1:0]          slv_r_resp_o,
  input  logic                slv_r_ready_i,
  input  logic                slv_aw_valid_i,
  input  logic [ADDR_W-1:0]   slv_aw_addr_i,
  output logic                slv_aw_ready_o,
  input  logic                slv_w_valid_i,
  input  logic [DATA_W-1:0]   slv_w_data_i,
  input  logic [DATA_W/8-1:0] slv_w_strb_i,
  output logic                slv_w_ready_o,
  output logic                slv_b_valid_o,
  output logic [1:0]          slv_b_resp_o,
  input  logic                slv_b_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = 16;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d, b_resp_q, b_resp_d;
  logic                ar_ready_q, ar_ready_d, aw_ok_q, aw_ok_d, w_ready_q, w_ready_d;
  logic                r_valid_q, r_valid_d, b_valid_q, b_valid_d;
  logic                mem_we, ready_gate;
  logic [CNT_W-1:0]    rd_load, wr_load;
  logic [ADDR_W-1:0]   offset;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    ready_gate = lfsr_d[7];
    rd_load    = CNT_W'(RD_LAT - 1) + CNT_W'(lfsr_q[2:0]);
    wr_load    = CNT_W'(WR_LAT - 1) + CNT_W'(lfsr_q[2:0]);
  end
`else
  always_comb begin
    ready_gate = 1'b1;
    rd_load    = CNT_W'(RD_LAT - 1);
    wr_load    = CNT_W'(WR_LAT - 1);
  end
`endif

  // Decode is done on the latched address so it is stable for the whole transaction.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ((offset >> LSB) < ADDR_W'(DEPTH_WORDS));
  assign idx      = offset[LSB +: IDX_W];

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    b_resp_d = b_resp_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (slv_ar_valid_i && ar_ready_q) begin
          addr_d  = slv_ar_addr_i;
          cnt_d   = rd_load;
          state_d = R_WAIT;
        end else if (slv_aw_valid_i && slv_aw_ready_o) begin
          addr_d  = slv_aw_addr_i;
          state_d = W_DATA;
        end
      end
      R_WAIT: begin
        if (cnt_q == '0) begin
          r_data_d = in_range ? mem[idx] : '0;
          r_resp_d = in_range ? RESP_OKAY : RESP_SLVERR;
          state_d  = R_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_RESP: if (r_valid_q && slv_r_ready_i) state_d = IDLE;
      W_DATA: begin
        if (slv_w_valid_i && w_ready_q) begin
          mem_we   = in_range && !rst_i;
          b_resp_d = in_range ? RESP_OKAY : RESP_SLVERR;
          cnt_d    = wr_load;
          state_d  = W_WAIT;
        end
      end
      W_WAIT: begin
        if (cnt_q == '0) state_d = B_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      B_RESP: if (b_valid_q && slv_b_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ar_ready_d = (state_d == IDLE) && ready_gate;
    aw_ok_d    = (state_d == IDLE) && ready_gate;
    w_ready_d  = (state_d == W_DATA);
    r_valid_d  = (state_d == R_RESP);
    b_valid_d  = (state_d == B_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      b_resp_q   <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
`ifdef AXIL_SRAM_RAND_DELAY_EN
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      b_resp_q   <= b_resp_d;
      ar_ready_q <= ar_ready_d;
      aw_ok_q    <= aw_ok_d;
      w_ready_q  <= w_ready_d;
      r_valid_q  <= r_valid_d;
      b_valid_q  <= b_valid_d;
`ifdef AXIL_SRAM_RAND_DELAY_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  // NOTE: the array has no reset; its contents survive rst_i and only written lanes change.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (slv_w_strb_i[b]) mem[idx][8*b +: 8] <= slv_w_data_i[8*b +: 8];
      end
    end
  end

  assign slv_ar_ready_o = ar_ready_q;
  assign slv_aw_ready_o = aw_ok_q && !slv_ar_valid_i;
  assign slv_w_ready_o  = w_ready_q;
  assign slv_r_valid_o  = r_valid_q;
  assign slv_r_data_o   = r_data_q;
  assign slv_r_resp_o   = r_resp_q;
  assign slv_b_valid_o  = b_valid_q;
  assign slv_b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_axil_sram.sv
// Self-checking bench for axil_sram: directed corner cases plus randomized traffic
// checked against a sparse word-array reference model.
module tb_axil_sram;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 1;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        slv_ar_valid_i, slv_ar_ready_o, slv_r_valid_o, slv_r_ready_i;
  logic [31:0] slv_ar_addr_i, slv_r_data_o, slv_aw_addr_i, slv_w_data_i;
  logic [1:0]  slv_r_resp_o, slv_b_resp_o;
  logic        slv_aw_valid_i, slv_aw_ready_o, slv_w_valid_i, slv_w_ready_o;
  logic [3:0]  slv_w_strb_i;
  logic        slv_b_valid_o, slv_b_ready_i;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [int];

  always #5 clk_i = ~clk_i;

  axil_sram dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o),
    .slv_r_ready_i(slv_r_ready_i),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i),
    .slv_w_ready_o(slv_w_ready_o),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_resp_o(slv_b_resp_o), .slv_b_ready_i(slv_b_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return slv_ar_ready_o;
      1:       return slv_aw_ready_o;
      2:       return slv_w_ready_o;
      3:       return slv_r_valid_o;
      default: return slv_b_valid_o;
    endcase
  endfunction

  // Waits at negedges until the selected signal is high; a bounded wait counts as a failure.
  task automatic wait_for(input int which, input string tag, output int n);
    n = 0;
    while (!sig_sel(which) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  task automatic txn_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
    int n;
    int widx;
    logic [31:0] d0;
    logic [1:0]  resp;
    slv_ar_addr_i  = addr;
    slv_ar_valid_i = 1'b1;
    wait_for(0, "ar", n);
    @(negedge clk_i);
    slv_ar_valid_i = 1'b0;
    wait_for(3, "r", n);
`ifndef AXIL_SRAM_RAND_DELAY_EN
    check("r_latency", 32'(n), 32'(RD_LAT));
`endif
    d0 = slv_r_data_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("r_valid_hold", {31'd0, slv_r_valid_o}, 32'd1);
      check("r_data_hold", slv_r_data_o, d0);
      check("ar_ready_busy", {31'd0, slv_ar_ready_o}, 32'd0);
      check("aw_ready_busy", {31'd0, slv_aw_ready_o}, 32'd0);
    end
    slv_r_ready_i = 1'b1;
    data = slv_r_data_o;
    resp = slv_r_resp_o;
    @(negedge clk_i);
    slv_r_ready_i = 1'b0;
    if (in_rng(addr)) begin
      widx = int'((addr - BASE) >> 2);
      check("r_resp", {30'd0, resp}, 32'd0);
      if (model.exists(widx)) check("r_data", data, model[widx]);
    end else begin
      check("r_resp_err", {30'd0, resp}, 32'd2);
      check("r_data_err", data, 32'd0);
    end
  endtask

  task automatic txn_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold);
    int n;
    int widx;
    logic [1:0]  resp;
    logic [31:0] w;
    slv_aw_addr_i  = addr;
    slv_aw_valid_i = 1'b1;
    slv_w_data_i   = data;
    slv_w_strb_i   = strb;
    slv_w_valid_i  = 1'b1;
    wait_for(1, "aw", n);
    @(negedge clk_i);
    slv_aw_valid_i = 1'b0;
    wait_for(2, "w", n);
    @(negedge clk_i);
    slv_w_valid_i = 1'b0;
    wait_for(4, "b", n);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("b_valid_hold", {31'd0, slv_b_valid_o}, 32'd1);
    end
    slv_b_ready_i = 1'b1;
    resp = slv_b_resp_o;
    @(negedge clk_i);
    slv_b_ready_i = 1'b0;
    if (in_rng(addr)) begin
      check("b_resp", {30'd0, resp}, 32'd0);
      widx = int'((addr - BASE) >> 2);
      w = model.exists(widx) ? model[widx] : 32'd0;
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      model[widx] = w;
    end else begin
      check("b_resp_err", {30'd0, resp}, 32'd2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int n;
    rst_i = 1'b1;
    slv_ar_valid_i = 0; slv_ar_addr_i = 0; slv_r_ready_i = 0;
    slv_aw_valid_i = 0; slv_aw_addr_i = 0; slv_w_valid_i = 0;
    slv_w_data_i = 0; slv_w_strb_i = 0; slv_b_ready_i = 0;
    repeat (3) @(negedge clk_i);
    check("rst_ar_ready", {31'd0, slv_ar_ready_o}, 32'd0);
    check("rst_aw_ready", {31'd0, slv_aw_ready_o}, 32'd0);
    check("rst_w_ready", {31'd0, slv_w_ready_o}, 32'd0);
    check("rst_r_valid", {31'd0, slv_r_valid_o}, 32'd0);
    check("rst_b_valid", {31'd0, slv_b_valid_o}, 32'd0);
    check("rst_r_data", slv_r_data_o, 32'd0);
    check("rst_resps", {28'd0, slv_r_resp_o, slv_b_resp_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
`ifndef AXIL_SRAM_RAND_DELAY_EN
    check("idle_ar_ready", {31'd0, slv_ar_ready_o}, 32'd1);
`endif

    // Full-word write then readback, then a single-lane update.
    txn_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    txn_read(32'h8000_0010, 0, d);
    check("deadbeef", d, 32'hDEAD_BEEF);
    txn_write(32'h8000_0010, 32'h0000_5A00, 4'b0010, 1);
    txn_read(32'h8000_0010, 0, d);
    check("dead5aef", d, 32'hDEAD_5AEF);

    // Out-of-range accesses; word 0 would alias index 1024 if the write leaked.
    txn_write(32'h8000_0000, 32'h1111_2222, 4'hF, 0);
    txn_read(32'h7FFF_FFFC, 0, d);
    txn_read(32'h8000_1000, 0, d);
    txn_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF, 0);
    txn_read(32'h8000_0000, 0, d);
    check("oor_no_alias", d, 32'h1111_2222);

    // Simultaneous AR and AW: read wins, write follows; R held for 5 cycles.
    slv_ar_addr_i  = 32'h8000_0010;
    slv_ar_valid_i = 1'b1;
    slv_aw_addr_i  = 32'h8000_0030;
    slv_aw_valid_i = 1'b1;
    slv_w_valid_i  = 1'b1;
    #1;
    check("both_aw_ready", {31'd0, slv_aw_ready_o}, 32'd0);
    check("both_w_ready", {31'd0, slv_w_ready_o}, 32'd0);
`ifndef AXIL_SRAM_RAND_DELAY_EN
    check("both_ar_ready", {31'd0, slv_ar_ready_o}, 32'd1);
`endif
    txn_read(32'h8000_0010, 5, d);
    check("both_read", d, 32'hDEAD_5AEF);
    txn_write(32'h8000_0030, 32'h0BAD_F00D, 4'hF, 0);
    txn_read(32'h8000_0030, 0, d);

    // Reset while the write response is pending: write stays, response is dropped.
    slv_aw_addr_i = 32'h8000_0020; slv_aw_valid_i = 1'b1;
    slv_w_data_i = 32'h1234_5678; slv_w_strb_i = 4'hF; slv_w_valid_i = 1'b1;
    wait_for(1, "rst_aw", n);
    @(negedge clk_i);
    slv_aw_valid_i = 1'b0;
    wait_for(2, "rst_w", n);
    @(negedge clk_i);
    slv_w_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_b_valid", {31'd0, slv_b_valid_o}, 32'd0);
    check("midrst_r_valid", {31'd0, slv_r_valid_o}, 32'd0);
    check("midrst_w_ready", {31'd0, slv_w_ready_o}, 32'd0);
    @(negedge clk_i);
    check("midrst_b_idle", {31'd0, slv_b_valid_o}, 32'd0);
`ifndef AXIL_SRAM_RAND_DELAY_EN
    check("midrst_idle", {31'd0, slv_ar_ready_o}, 32'd1);
`endif
    model[8] = 32'h1234_5678;
    txn_read(32'h8000_0020, 0, d);

    // Randomized traffic over a small pre-initialised window plus out-of-range addresses.
    for (int i = 0; i < 16; i++) txn_write(BASE + 32'(4 * i), $urandom, 4'hF, 0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = BASE - 32'(4 * $urandom_range(1, 64));
          1:       a = BASE + 32'h1000 + 32'($urandom_range(0, 4095));
          default: a = 32'($urandom_range(0, 32'h7FFF_FFFF));
        endcase
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0) txn_read(a, $urandom_range(0, 3), d);
      else txn_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
